// File: rtl/tape_ear_mixer.sv
// tape_ear_mixer: builds the ULA EAR input bit from the tape player output or a
// glitch-filtered external EAR pin, drives a tape-activity LED, mixes speaker/MIC
// into an 8-bit PCM level and converts it to a 1-bit sigma-delta DAC stream.
// Optional feature macro: TAPE_MONITOR_EN (adds the EAR level to the PCM mix).
module tape_ear_mixer #(
    parameter int unsigned CLK_HZ     = 28000000,
    parameter int unsigned ACT_MS     = 500,
    parameter int unsigned GLITCH_CYC = 16,
    parameter logic [7:0]  SPK_LVL    = 8'd128,
    parameter logic [7:0]  MIC_LVL    = 8'd32,
    parameter logic [7:0]  EAR_LVL    = 8'd64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tape_in,
    input  logic       ear_ext,
    input  logic       speaker,
    input  logic       mic,
    output logic       ear_out,
    output logic       tape_led,
    output logic [7:0] pcm,
    output logic       dac_out
);

    localparam int unsigned ACT_TICKS = CLK_HZ / 1000 * ACT_MS;
    localparam int unsigned ACT_W     = $clog2(ACT_TICKS + 1);
    localparam int unsigned GL_W      = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;

    localparam logic [ACT_W-1:0] ACT_RELOAD = ACT_W'(ACT_TICKS);
    localparam logic [GL_W-1:0]  GL_LAST    = GL_W'(GLITCH_CYC - 1);

`ifdef TAPE_MONITOR_EN
    localparam bit MONITOR = 1'b1;
`else
    // Constant-folds the monitor term away entirely.
    localparam bit MONITOR = 1'b0;
`endif

    logic             tape_q, tape_qq;
    logic             tape_edge;
    logic [ACT_W-1:0] act_cnt_q, act_cnt_d;
    logic             ext_s0_q, ext_s_q;
    logic             ext_filt_q, ext_filt_d;
    logic [GL_W-1:0]  glitch_q, glitch_d;
    logic             ear_d;
    logic [9:0]       sum;
    logic [7:0]       pcm_d;
    logic [8:0]       acc_q;

    assign tape_edge = tape_q ^ tape_qq;

    // Activity counter: reload on any tape edge (reload beats the decrement), saturate at 0.
    always_comb begin
        act_cnt_d = act_cnt_q;
        if (tape_edge) begin
            act_cnt_d = ACT_RELOAD;
        end else if (act_cnt_q != '0) begin
            act_cnt_d = act_cnt_q - 1'b1;
        end
    end

    // Glitch filter: accept a new external level only after GLITCH_CYC mismatching samples.
    always_comb begin
        ext_filt_d = ext_filt_q;
        glitch_d   = '0;
        if (ext_s_q != ext_filt_q) begin
            if (glitch_q == GL_LAST) begin
                ext_filt_d = ext_s_q;
            end else begin
                glitch_d = glitch_q + 1'b1;
            end
        end
    end

    // EAR select: tape wins while an edge is seen or the hold is still running.
    always_comb begin
        ear_d = ext_filt_q;
        if (tape_edge || (act_cnt_q != '0)) begin
            ear_d = tape_q;
        end
    end

    // Mixer with saturation to 8 bits.
    always_comb begin
        sum = 10'd0;
        if (speaker) begin
            sum = sum + {2'b00, SPK_LVL};
        end
        if (mic) begin
            sum = sum + {2'b00, MIC_LVL};
        end
        if (MONITOR && ear_out) begin
            sum = sum + {2'b00, EAR_LVL};
        end
        pcm_d = (sum > 10'd255) ? 8'hFF : sum[7:0];
    end

    // Tape synchronisation, activity hold and LED.
    always_ff @(posedge clk) begin
        if (reset) begin
            tape_q    <= 1'b0;
            tape_qq   <= 1'b0;
            act_cnt_q <= '0;
            tape_led  <= 1'b0;
        end else begin
            tape_q    <= tape_in;
            tape_qq   <= tape_q;
            act_cnt_q <= act_cnt_d;
            tape_led  <= (act_cnt_d != '0);
        end
    end

    // External EAR synchroniser and glitch filter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_s0_q   <= 1'b0;
            ext_s_q    <= 1'b0;
            ext_filt_q <= 1'b0;
            glitch_q   <= '0;
        end else begin
            ext_s0_q   <= ear_ext;
            ext_s_q    <= ext_s0_q;
            ext_filt_q <= ext_filt_d;
            glitch_q   <= glitch_d;
        end
    end

    // Registered outputs: EAR bit, PCM level and sigma-delta modulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            ear_out <= 1'b0;
            pcm     <= 8'd0;
            acc_q   <= 9'd0;
            dac_out <= 1'b0;
        end else begin
            ear_out <= ear_d;
            pcm     <= pcm_d;
            acc_q   <= {1'b0, acc_q[7:0]} + {1'b0, pcm};
            dac_out <= acc_q[8];
        end
    end

endmodule
